mult4s_accum_stage: RTL and testbench

Downstream accumulation stage for the registered 4x4 signed multiplier wrapper. It consumes the wrapper's 8-bit signed `product` stream through a valid/ready handshake and sums groups of `TERMS` products, or shorter groups closed by `in_last`, into a signed accumulator. Each completed dot-product is presented through a one-entry output register with its own valid/ready handshake. This is the MAC back end of the multiplier test designs.

---
 rtl/mult4s_accum_stage.sv | 99 +++++++++
 tb/tb_mult4s_accum_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult4s_accum_stage.sv
// rtl/mult4s_accum_stage.sv - signed MAC back end summing groups of 8-bit products with a one-entry result register
// Optional MULT4S_ACCUM_SAT_EN clamps on signed overflow instead of wrapping.
module mult4s_accum_stage #(
  parameter int ACC_W = 12,
  parameter int TERMS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf
);

  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(TERMS - 1);
`ifdef MULT4S_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  logic signed [ACC_W-1:0] t;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] nxt;
  logic                    add_ovf;
  logic                    ovf_next;
  logic                    at_last;
  logic                    closing;
  logic                    accept;

  always_comb begin
    t        = ACC_W'(product);
    sum      = acc + t;
    add_ovf  = (acc[ACC_W-1] == t[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    nxt      = t;
    ovf_next = 1'b0;
    // The first term of a group overwrites acc, so stale acc/ovf never leak in.
    if (cnt != '0) begin
      nxt      = sum;
      ovf_next = ovf | add_ovf;
`ifdef MULT4S_ACCUM_SAT_EN
      if (add_ovf) begin
        nxt = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end
`endif
    end
  end

  always_comb begin
    at_last  = (cnt == LAST_POS);
    closing  = at_last || in_last;
    // A closing term may only enter when the result slot is free or draining.
    in_ready = !clr
               && (!at_last || !out_valid || out_ready)
               && !(in_valid && in_last && out_valid && !out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        if (closing) begin
          out_sum   <= nxt;
          out_ovf   <= ovf_next;
          out_valid <= 1'b1;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          ovf <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult4s_accum_stage.sv
// tb/tb_mult4s_accum_stage.sv - directed vector bench for mult4s_accum_stage
module tb_mult4s_accum_stage;

  typedef struct {
    int prod;
    bit last;
    bit exp_v;
    int exp_sum;
    bit exp_ovf;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  product = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [11:0] out_sum;
  logic               out_ovf;

  logic               v2 = 1'b0;
  logic               r2;
  logic signed [7:0]  p2 = '0;
  logic               l2 = 1'b0;
  logic               ov2;
  logic signed [7:0]  s2;
  logic               f2;

  int total = 0;
  int bad = 0;

  vec_t vecs[16];
  vec_t ovecs[6];

  mult4s_accum_stage #(.ACC_W(12), .TERMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  mult4s_accum_stage #(.ACC_W(8), .TERMS(2)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(v2), .in_ready(r2),
    .product(p2), .in_last(l2), .out_valid(ov2), .out_ready(1'b1),
    .out_sum(s2), .out_ovf(f2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit l, input string name);
    in_valid = 1'b1;
    product  = 8'(p);
    in_last  = l;
    #1;
    chk({name, " in_ready"}, int'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3, 0, 0, 0, 0};
    vecs[1]  = '{-5, 0, 0, 0, 0};
    vecs[2]  = '{7, 0, 0, 0, 0};
    vecs[3]  = '{2, 0, 1, 7, 0};
    vecs[4]  = '{10, 0, 0, 0, 0};
    vecs[5]  = '{-20, 1, 1, -10, 0};
    vecs[6]  = '{1, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 4, 0};
    vecs[10] = '{-128, 0, 0, 0, 0};
    vecs[11] = '{-128, 0, 0, 0, 0};
    vecs[12] = '{-128, 0, 0, 0, 0};
    vecs[13] = '{-128, 0, 1, -512, 0};
    vecs[14] = '{5, 1, 1, 5, 0};
    vecs[15] = '{6, 1, 1, 6, 0};

    ovecs[0] = '{100, 0, 0, 0, 0};
`ifdef MULT4S_ACCUM_SAT_EN
    ovecs[1] = '{100, 0, 1, 127, 1};
    ovecs[3] = '{-100, 0, 1, -128, 1};
`else
    ovecs[1] = '{100, 0, 1, -56, 1};
    ovecs[3] = '{-100, 0, 1, 56, 1};
`endif
    ovecs[2] = '{-100, 0, 0, 0, 0};
    ovecs[4] = '{100, 0, 0, 0, 0};
    ovecs[5] = '{-100, 0, 1, 0, 0};

    // reset state
    cycle();
    cycle();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_sum", int'(out_sum), 0);
    chk("reset out_ovf", int'(out_ovf), 0);
    chk("reset in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    cycle();

    // streaming vectors with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      product  = 8'(vecs[i].prod);
      in_last  = vecs[i].last;
      #1;
      chk($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
      cycle();
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d out_sum", i), int'(out_sum), vecs[i].exp_sum);
        chk($sformatf("vec%0d out_ovf", i), int'(out_ovf), int'(vecs[i].exp_ovf));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    cycle();
    chk("stream drained out_valid", int'(out_valid), 0);

    // backpressure
    out_ready = 1'b0;
    send(1, 0, "bp g1 t0");
    send(2, 0, "bp g1 t1");
    send(3, 0, "bp g1 t2");
    send(4, 0, "bp g1 t3");
    chk("bp g1 out_valid", int'(out_valid), 1);
    chk("bp g1 out_sum", int'(out_sum), 10);
    in_valid = 1'b1;
    product  = 8'(7);
    in_last  = 1'b1;
    #1;
    chk("bp last stall in_ready", int'(in_ready), 0);
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp last stall out_sum", int'(out_sum), 10);
    for (int k = 0; k < 3; k++) begin
      send(1, 0, $sformatf("bp g2 t%0d", k));
      chk($sformatf("bp g2 t%0d held sum", k), int'(out_sum), 10);
      chk($sformatf("bp g2 t%0d held valid", k), int'(out_valid), 1);
    end
    in_valid = 1'b1;
    product  = 8'(1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp stall%0d in_ready", k), int'(in_ready), 0);
      cycle();
      chk($sformatf("bp stall%0d out_sum", k), int'(out_sum), 10);
      chk($sformatf("bp stall%0d out_valid", k), int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", int'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    chk("bp handover out_valid", int'(out_valid), 1);
    chk("bp handover out_sum", int'(out_sum), 4);
    cycle();
    chk("bp after out_valid", int'(out_valid), 0);

    // clr drops the partial group and the coincident term
    send(5, 0, "clr t0");
    send(5, 0, "clr t1");
    clr      = 1'b1;
    in_valid = 1'b1;
    product  = 8'(9);
    #1;
    chk("clr in_ready", int'(in_ready), 0);
    cycle();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr out_valid", int'(out_valid), 0);
    send(1, 0, "clr g t0");
    send(1, 0, "clr g t1");
    send(1, 0, "clr g t2");
    send(1, 0, "clr g t3");
    chk("clr g out_valid", int'(out_valid), 1);
    chk("clr g out_sum", int'(out_sum), 4);
    cycle();

    // async reset with a held result and a partial group
    out_ready = 1'b0;
    send(3, 0, "rst g t0");
    send(3, 0, "rst g t1");
    send(3, 0, "rst g t2");
    send(3, 0, "rst g t3");
    chk("rst held out_sum", int'(out_sum), 12);
    send(5, 0, "rst p t0");
    send(5, 0, "rst p t1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", int'(out_valid), 0);
    chk("rst async out_sum", int'(out_sum), 0);
    chk("rst async in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    send(2, 0, "rst n t0");
    send(2, 0, "rst n t1");
    send(2, 0, "rst n t2");
    send(2, 0, "rst n t3");
    chk("rst new out_valid", int'(out_valid), 1);
    chk("rst new out_sum", int'(out_sum), 8);
    cycle();

    // overflow, ACC_W=8 TERMS=2
    for (int i = 0; i < 6; i++) begin
      v2 = 1'b1;
      p2 = 8'(ovecs[i].prod);
      l2 = ovecs[i].last;
      #1;
      chk($sformatf("ovf%0d in_ready", i), int'(r2), 1);
      cycle();
      chk($sformatf("ovf%0d out_valid", i), int'(ov2), int'(ovecs[i].exp_v));
      if (ovecs[i].exp_v) begin
        chk($sformatf("ovf%0d out_sum", i), int'(s2), ovecs[i].exp_sum);
        chk($sformatf("ovf%0d out_ovf", i), int'(f2), int'(ovecs[i].exp_ovf));
      end
    end
    v2 = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
